// File: rtl/apb_dec_pkg.sv
// Shared types and default region map for the APB region decoder.
// Contents: FSM state enum, default geometry constants and derived widths.
// No logic; imported by apb_region_match and apb_region_decoder.
package apb_dec_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TOERR  = 2'd2
  } state_t;

  localparam int DEF_ADDR_W         = 8;
  localparam int DEF_DATA_W         = 32;
  localparam int DEF_NUM_REGIONS    = 5;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  // Region k lives in slice k: 0x00-0x0F, 0x10-0x1F, 0x20-0x2F, 0x30-0x3F, 0x40-0x7F.
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_BASE_ADDRS = 40'h40_30_20_10_00;
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_ADDR_MASKS = 40'hC0_F0_F0_F0_F0;

  // Timeout counter width and slave index width for the default geometry.
  localparam int DEF_CNT_W = $clog2(DEF_TIMEOUT_CYCLES + 1);
  localparam int DEF_IDX_W = $clog2(DEF_NUM_REGIONS);

endpackage

// File: rtl/apb_region_match.sv
// Purpose : mask/compare of an address against every region, lowest index wins.
// Latency : purely combinational. Backpressure: none (no state).
// Ports   : addr -> hit (one-hot or zero), unmapped (no region matched).
module apb_region_match
  import apb_dec_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS
) (
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] hit,
  output logic                   unmapped
);

  logic [NUM_REGIONS-1:0] raw_hit;
  logic                   found;

  always_comb begin
    for (int k = 0; k < NUM_REGIONS; k++) begin
      raw_hit[k] = ((addr & ADDR_MASKS[k*ADDR_W +: ADDR_W]) == BASE_ADDRS[k*ADDR_W +: ADDR_W]);
    end
  end

  // Priority encode so overlapping regions still yield a single select.
  always_comb begin
    hit   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (raw_hit[k] && !found) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    unmapped = !found;
  end

endmodule

// File: rtl/apb_region_decoder.sv
// Purpose : APB address decoder with registered one-hot slave selects, response mux,
//           slave timeout and sticky error log.
// Latency : sel_o valid from the first access cycle; unmapped errors answer with zero wait states.
// Backpressure: slave pready stretches the access phase up to TIMEOUT_CYCLES, then a forced error.
// Ports   : APB master side (psel/penable/paddr -> pready/pslverr/prdata), per-slave
//           select/ready/error/data, error log (err_valid/err_addr, err_clr).
module apb_region_decoder
  import apb_dec_pkg::*;
#(
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int DATA_W         = DEF_DATA_W,
  parameter int NUM_REGIONS    = DEF_NUM_REGIONS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] BASE_ADDRS = DEF_BASE_ADDRS,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] ADDR_MASKS = DEF_ADDR_MASKS,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          psel_i,
  input  logic                          penable_i,
  input  logic [ADDR_W-1:0]             paddr_i,
  output logic                          pready_o,
  output logic                          pslverr_o,
  output logic [DATA_W-1:0]             prdata_o,
  output logic [NUM_REGIONS-1:0]        sel_o,
  input  logic [NUM_REGIONS-1:0]        slv_pready_i,
  input  logic [NUM_REGIONS-1:0]        slv_pslverr_i,
  input  logic [NUM_REGIONS*DATA_W-1:0] slv_prdata_i,
  output logic                          err_valid_o,
  output logic [ADDR_W-1:0]             err_addr_o,
  input  logic                          err_clr_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                 state;
  logic [ADDR_W-1:0]      addr_q;
  logic                   unmapped_q;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_REGIONS-1:0] hit;
  logic                   unmapped;
  logic                   sel_rdy;
  logic                   sel_err;
  logic [DATA_W-1:0]      sel_rdata;

  apb_region_match #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .BASE_ADDRS  (BASE_ADDRS),
    .ADDR_MASKS  (ADDR_MASKS)
  ) u_match (
    .addr     (paddr_i),
    .hit      (hit),
    .unmapped (unmapped)
  );

  // sel_o is one-hot or zero, so an AND-OR mux is sufficient.
  always_comb begin
    sel_rdy   = |(slv_pready_i & sel_o);
    sel_err   = |(slv_pslverr_i & sel_o);
    sel_rdata = '0;
    for (int k = 0; k < NUM_REGIONS; k++) begin
      if (sel_o[k]) sel_rdata = sel_rdata | slv_prdata_i[k*DATA_W +: DATA_W];
    end
  end

  // Response to the master. Gated by psel_i in ACCESS so an aborted transfer never responds.
  always_comb begin
    pready_o  = 1'b0;
    pslverr_o = 1'b0;
    prdata_o  = '0;
    unique case (state)
      ACCESS: begin
        if (psel_i) begin
          if (unmapped_q) begin
            pready_o  = 1'b1;
            pslverr_o = 1'b1;
          end else begin
            pready_o  = sel_rdy;
            pslverr_o = sel_err;
            prdata_o  = sel_rdata;
          end
        end
      end
      TOERR: begin
        pready_o  = 1'b1;
        pslverr_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      addr_q      <= '0;
      unmapped_q  <= 1'b0;
      cnt         <= '0;
      sel_o       <= '0;
      err_valid_o <= 1'b0;
      err_addr_o  <= '0;
    end else begin
      // An errored completion beats a coincident clear.
      if (pready_o && pslverr_o) begin
        err_valid_o <= 1'b1;
        err_addr_o  <= addr_q;
      end else if (err_clr_i) begin
        err_valid_o <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (psel_i && !penable_i) begin
            addr_q     <= paddr_i;
            sel_o      <= hit;
            unmapped_q <= unmapped;
            cnt        <= '0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          if (!psel_i) begin
            state <= IDLE;
            sel_o <= '0;
          end else if (unmapped_q) begin
            state <= IDLE;
          end else if (sel_rdy) begin
            state <= IDLE;
            sel_o <= '0;
          end else begin
            if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
            // The slave is abandoned here; its select drops for the error cycle.
            if (cnt >= TO_LAST) begin
              state <= TOERR;
              sel_o <= '0;
            end
          end
        end
        TOERR: begin
          state <= IDLE;
          sel_o <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_region_decoder.sv
module tb_apb_region_decoder;

  localparam int T = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         psel, penable;
  logic [7:0]   paddr;
  logic         pready, pslverr;
  logic [31:0]  prdata;
  logic [4:0]   sel;
  logic [4:0]   slv_pready, slv_pslverr;
  logic [159:0] slv_prdata;
  logic         err_valid;
  logic [7:0]   err_addr;
  logic         err_clr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference error-log state.
  logic       m_err_valid = 1'b0;
  logic [7:0] m_err_addr  = 8'h00;

  always #5 clk = ~clk;

  apb_region_decoder dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .psel_i        (psel),
    .penable_i     (penable),
    .paddr_i       (paddr),
    .pready_o      (pready),
    .pslverr_o     (pslverr),
    .prdata_o      (prdata),
    .sel_o         (sel),
    .slv_pready_i  (slv_pready),
    .slv_pslverr_i (slv_pslverr),
    .slv_prdata_i  (slv_prdata),
    .err_valid_o   (err_valid),
    .err_addr_o    (err_addr),
    .err_clr_i     (err_clr)
  );

  // Default map as address ranges: 16-byte regions 0..3 below 0x40, region 4 is 0x40-0x7F.
  function automatic int model_region(input logic [7:0] a);
    if (a < 8'h40) return int'(a >> 4);
    if (a < 8'h80) return 4;
    return -1;
  endfunction

  // One APB transfer: setup cycle then access cycles until the model says it completes.
  task automatic run_xfer(input logic [7:0] addr, input int lat, input logic serr,
                          input logic [31:0] tdata);
    int          region;
    int          i;
    bit          done;
    bit          toerr;
    logic [31:0] sdata [5];
    logic [4:0]  exp_sel;
    logic        exp_rdy, exp_err;
    logic [31:0] exp_dat;
    region  = model_region(addr);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    slv_pready  = 5'($urandom);
    slv_pslverr = 5'($urandom);
    @(negedge clk);
    n_cmp++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0) begin
      n_fail++;
      $display("FAIL setup_idle addr=%h: pready=%b pslverr=%b prdata=%h, required 0/0/0",
               addr, pready, pslverr, prdata);
    end
    @(posedge clk); #1;
    if (err_clr) m_err_valid = 1'b0;
    penable = 1'b1;
    done = 1'b0;
    i = 0;
    while (!done) begin
      for (int k = 0; k < 5; k++) sdata[k] = $urandom;
      if (region >= 0) sdata[region] = tdata;
      for (int k = 0; k < 5; k++) slv_prdata[k*32 +: 32] = sdata[k];
      slv_pready  = 5'($urandom);
      slv_pslverr = 5'($urandom);
      if (region >= 0) begin
        slv_pready[region]  = (i >= lat);
        slv_pslverr[region] = serr;
      end
      toerr = 1'b0;
      if (region < 0) begin
        exp_sel = 5'b0; exp_rdy = 1'b1; exp_err = 1'b1; exp_dat = 32'h0; done = 1'b1;
      end else if (i >= T) begin
        toerr = 1'b1;
        exp_sel = 5'b0; exp_rdy = 1'b1; exp_err = 1'b1; exp_dat = 32'h0; done = 1'b1;
      end else begin
        exp_sel = 5'(1 << region);
        exp_rdy = (i >= lat);
        exp_err = serr;
        exp_dat = tdata;
        done    = exp_rdy;
      end
      @(negedge clk);
      if (!toerr) begin
        n_cmp++;
        if (sel !== exp_sel) begin
          n_fail++;
          $display("FAIL sel addr=%h cyc=%0d: got %b, required %b", addr, i, sel, exp_sel);
        end
      end
      n_cmp++;
      if (pready !== exp_rdy) begin
        n_fail++;
        $display("FAIL pready addr=%h cyc=%0d: got %b, required %b", addr, i, pready, exp_rdy);
      end
      n_cmp++;
      if (pslverr !== exp_err) begin
        n_fail++;
        $display("FAIL pslverr addr=%h cyc=%0d: got %b, required %b", addr, i, pslverr, exp_err);
      end
      n_cmp++;
      if (prdata !== exp_dat) begin
        n_fail++;
        $display("FAIL prdata addr=%h cyc=%0d: got %h, required %h", addr, i, prdata, exp_dat);
      end
      @(posedge clk); #1;
      if (done && exp_err) begin
        m_err_valid = 1'b1;
        m_err_addr  = addr;
      end else if (err_clr) begin
        m_err_valid = 1'b0;
      end
      i++;
    end
    n_cmp++;
    if (sel !== 5'b0) begin
      n_fail++;
      $display("FAIL sel_after addr=%h: got %b, required 00000", addr, sel);
    end
    n_cmp++;
    if (err_valid !== m_err_valid || err_addr !== m_err_addr) begin
      n_fail++;
      $display("FAIL err_log addr=%h: got valid=%b addr=%h, required valid=%b addr=%h",
               addr, err_valid, err_addr, m_err_valid, m_err_addr);
    end
  endtask

  task automatic idle(input int n);
    psel    = 1'b0;
    penable = 1'b0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      n_cmp++;
      if (pready !== 1'b0 || pslverr !== 1'b0 || sel !== 5'b0) begin
        n_fail++;
        $display("FAIL idle: pready=%b pslverr=%b sel=%b, required 0/0/00000", pready, pslverr, sel);
      end
      @(posedge clk); #1;
      if (err_clr) m_err_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; psel = 1'b0; penable = 1'b0; paddr = 8'h00; err_clr = 1'b0;
    slv_pready = 5'b0; slv_pslverr = 5'b0; slv_prdata = '1;
    #3;
    n_cmp++;
    if (sel !== 5'b0 || pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 ||
        err_valid !== 1'b0 || err_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: sel=%b pready=%b pslverr=%b prdata=%h ev=%b ea=%h, required all 0",
               sel, pready, pslverr, prdata, err_valid, err_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
  endtask

  task automatic test_basic();
    run_xfer(8'h10, 0, 1'b0, 32'hDEADBEEF);
    idle(1);
    run_xfer(8'h5A, 3, 1'b0, 32'h1234_5678);
    idle(1);
    run_xfer(8'h2C, 0, 1'b1, 32'hCAFE_0001);
    idle(1);
  endtask

  task automatic test_unmapped();
    run_xfer(8'hA0, 0, 1'b0, 32'h0);
    idle(1);
  endtask

  task automatic test_timeout();
    run_xfer(8'h30, T - 1, 1'b0, 32'h0BAD_F00D);
    idle(1);
    run_xfer(8'h30, 1000, 1'b0, 32'h0);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    n_cmp++;
    if (err_valid !== 1'b0 || err_addr !== 8'h30) begin
      n_fail++;
      $display("FAIL err_clr: got valid=%b addr=%h, required valid=0 addr=30", err_valid, err_addr);
    end
  endtask

  task automatic test_clr_vs_set();
    run_xfer(8'h90, 0, 1'b0, 32'h0);
    err_clr = 1'b1;
    run_xfer(8'hC4, 0, 1'b0, 32'h0);
    err_clr = 1'b0;
    idle(1);
  endtask

  task automatic test_mid_reset();
    psel = 1'b1; penable = 1'b0; paddr = 8'h20;
    @(posedge clk); #1;
    penable = 1'b1; slv_pready = 5'b0; slv_pslverr = 5'b0; slv_prdata = '1;
    @(posedge clk); #1;
    n_cmp++;
    if (sel !== 5'b00100) begin
      n_fail++;
      $display("FAIL mid_reset_pre_sel: got %b, required 00100", sel);
    end
    #2 rst = 1'b1;
    #1;
    m_err_valid = 1'b0;
    m_err_addr  = 8'h00;
    n_cmp++;
    if (sel !== 5'b0 || pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 ||
        err_valid !== 1'b0 || err_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_reset: sel=%b pready=%b pslverr=%b prdata=%h ev=%b ea=%h, required all 0",
               sel, pready, pslverr, prdata, err_valid, err_addr);
    end
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_xfer(8'h00, 0, 1'b0, 32'h0000_00A5);
    idle(1);
  endtask

  task automatic test_abort_back_to_back();
    logic ev_before;
    run_xfer(8'hF0, 0, 1'b0, 32'h0);
    ev_before = m_err_valid;
    psel = 1'b1; penable = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    penable = 1'b1; slv_pready = 5'b0; slv_pslverr = 5'b11111;
    @(negedge clk);
    n_cmp++;
    if (sel !== 5'b00010 || pready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre: sel=%b pready=%b, required 00010/0", sel, pready);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (pready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_resp: pready=%b, required 0", pready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (sel !== 5'b0 || err_valid !== ev_before || err_addr !== m_err_addr) begin
      n_fail++;
      $display("FAIL abort_post: sel=%b ev=%b ea=%h, required 00000/%b/%h",
               sel, err_valid, err_addr, ev_before, m_err_addr);
    end
    run_xfer(8'h10, 0, 1'b0, 32'h1111_2222);
    run_xfer(8'h20, 0, 1'b0, 32'h3333_4444);
    run_xfer(8'h47, 2, 1'b1, 32'h5555_6666);
    idle(1);
  endtask

  task automatic test_random();
    logic [7:0] a;
    int         lat;
    logic       serr;
    for (int n = 0; n < 40; n++) begin
      a       = 8'($urandom);
      lat     = $urandom_range(0, 20);
      serr    = ($urandom_range(0, 3) == 0);
      err_clr = ($urandom_range(0, 4) == 0);
      run_xfer(a, lat, serr, $urandom);
      err_clr = 1'b0;
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_unmapped();
    test_timeout();
    test_clr_vs_set();
    test_mid_reset();
    test_abort_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_region_decoder.md
Name: apb_region_decoder

Overview:
- Parametrised APB address decoder with registered one-hot slave selects, replacing the fixed 3-bit, 5-target combinational decoder.
- Sits between the APB master port and NUM_REGIONS slave register blocks (Mat A, Mat B, control, flags, SP, and later additions).
- Adds an APB transfer FSM and read-data/ready muxing from the selected slave.
- Returns PSLVERR for unmapped addresses and for slaves that time out, and records the last faulting address.

Parameters:
- ADDR_W, 8: APB address width.
- DATA_W, 32: APB data width.
- NUM_REGIONS, 5: number of slave regions.
- BASE_ADDRS, {8'h40,8'h30,8'h20,8'h10,8'h00}: packed NUM_REGIONS*ADDR_W region bases; region k occupies slice k.
- ADDR_MASKS, {8'hC0,8'hF0,8'hF0,8'hF0,8'hF0}: packed masks. Region k hits when (paddr & MASK_k) == BASE_k.
- TIMEOUT_CYCLES, 16: access-phase cycles without slave ready before a forced error; range 2..255.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- psel_i  in  1  APB select from master.
- penable_i  in  1  APB enable.
- paddr_i  in  ADDR_W  APB address.
- pready_o  out  1  ready to master.
- pslverr_o  out  1  error to master.
- prdata_o  out  DATA_W  read data to master.
- sel_o  out  NUM_REGIONS  registered one-hot slave select.
- slv_pready_i  in  NUM_REGIONS  per-slave ready.
- slv_pslverr_i  in  NUM_REGIONS  per-slave error.
- slv_prdata_i  in  NUM_REGIONS*DATA_W  per-slave read data, packed.
- err_valid_o  out  1  sticky flag: an error response has occurred.
- err_addr_o  out  ADDR_W  address of the most recent errored transfer.
- err_clr_i  in  1  clears err_valid_o.

Behaviour:
- Reset (asynchronous, active-high; applies even mid-transfer):
  - state = IDLE.
  - sel_o, pready_o, pslverr_o, prdata_o, err_valid_o, err_addr_o, and the timeout counter all = 0.
- Decode:
  - hit[k] = ((paddr_i & MASK_k) == BASE_k).
  - Overlapping regions resolve to the lowest k, so the result is always one-hot or zero.
- FSM states: IDLE, ACCESS, TOERR.
- IDLE:
  - pready_o = 0.
  - On psel_i && !penable_i (setup phase): latch paddr_i, register the priority-encoded hit into sel_o and an unmapped flag, clear the counter, go to ACCESS.
  - sel_o is therefore valid from the first access cycle (one-cycle latency).
- ACCESS, unmapped:
  - pready_o = 1 and pslverr_o = 1 in the first access cycle (zero wait states), prdata_o = 0.
  - Go to IDLE.
- ACCESS, mapped to slave k:
  - pready_o, pslverr_o and prdata_o are combinational from slave k.
  - On slv_pready_i[k]: go to IDLE and clear sel_o.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 without ready, go to TOERR.
- TOERR:
  - Exactly one cycle with pready_o = 1, pslverr_o = 1, prdata_o = 0.
  - sel_o cleared; go to IDLE.
- Protocol abort: psel_i low while in ACCESS → go to IDLE, clear sel_o, no response, no error logged.
- Back-to-back: the next setup is accepted in the IDLE cycle after completion. There are no idle bubbles beyond APB's mandatory setup cycle.
- Error log:
  - Any completion with pslverr_o = 1 (unmapped, timeout or slave error) sets err_valid_o and loads err_addr_o with the latched address.
  - err_clr_i clears err_valid_o. If it coincides with a new error, the set wins.
  - err_addr_o holds its value until the next error.
- Outside ACCESS/TOERR: prdata_o = 0 and pslverr_o = 0.
- The counter saturates and never wraps.

Decomposition:
- Shared package apb_dec_pkg holds:
  - the state enum (IDLE, ACCESS, TOERR);
  - localparam widths: counter width = $clog2(TIMEOUT_CYCLES+1), index width = $clog2(NUM_REGIONS);
  - the default region map constants.
- One sub-module: apb_region_match. Purely combinational: mask/compare over NUM_REGIONS plus a priority encoder, outputting a one-hot hit and an unmapped flag.
- The FSM, muxing and error log live in the top module.

Test Plan:
- Setup at paddr=8'h10, slave 1 ready in the first access cycle → sel_o = 5'b00010 from access cycle 1, pready_o = 1 that cycle, prdata_o = slave 1 data 32'hDEADBEEF.
- Access at paddr=8'h5A (region 4) with slave 4 ready held low 3 cycles → sel_o = 5'b10000 for 4 access cycles, pready_o rises on the 4th, pslverr_o = 0.
- Access at paddr=8'hA0 (unmapped) → pready_o = 1, pslverr_o = 1 in the first access cycle, sel_o = 0, err_valid_o = 1, err_addr_o = 8'hA0.
- Access at paddr=8'h30 with slave 3 never ready, TIMEOUT_CYCLES=16 → TOERR after 16 access cycles, pslverr_o = 1, err_addr_o = 8'h30; err_clr_i pulse → err_valid_o = 0.
- Assert rst_i mid-ACCESS (paddr=8'h20, waiting) → all outputs 0 asynchronously; the next setup at 8'h00 decodes to sel_o = 5'b00001.
- Drop psel_i in ACCESS → IDLE, sel_o = 0, err_valid_o unchanged; a back-to-back transfer to 8'h10 then 8'h20 → selects 5'b00010 then 5'b00100 with no extra idle cycle.
